button_debouncer: RTL and testbench

- Front-end conditioning stage for raw board inputs (push-buttons, slide switches) in the basics project series.
- Synchronises an asynchronous pin into the clock domain and filters contact bounce with a counter-based FSM.
- Produces a clean level plus single-cycle edge pulses. Downstream logic-gate blocks, such as the 1-bit inverter used for active-low buttons, consume these outputs.

---
 rtl/button_debouncer_if.sv | 20 ++
 rtl/button_debouncer.sv | 139 +++++++++++++
 tb/tb_button_debouncer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/button_debouncer_if.sv
// Signal bundle between a raw board pin and the debouncer.
// dbg_state exposes the debouncer FSM state for checkers.
interface button_debouncer_if;
  logic       btn_in;
  logic       db_out;
  logic       rise_pulse;
  logic       fall_pulse;
  logic       toggle_out;
  logic [1:0] dbg_state;

  // master drives the raw pin and observes results; slave is the debouncer.
  modport master (
    output btn_in,
    input  db_out, rise_pulse, fall_pulse, toggle_out, dbg_state
  );
  modport slave (
    input  btn_in,
    output db_out, rise_pulse, fall_pulse, toggle_out, dbg_state
  );
endinterface

// File: rtl/button_debouncer.sv
// Synchroniser plus counter-qualified debounce FSM with registered level and edge pulses.
// Define DEBOUNCER_TOGGLE_EN to build the press-toggle flop behind toggle_out.
module button_debouncer #(
  parameter int unsigned STABLE_CYCLES = 500000,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter logic        RESET_LEVEL   = 1'b0
) (
  input logic               clk,
  input logic               rst,
  button_debouncer_if.slave bus
);

  localparam int unsigned CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  localparam state_t RESET_STATE = RESET_LEVEL ? STABLE_HI : STABLE_LO;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   db_q, db_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], bus.btn_in};
    state_d = state_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      STABLE_LO: begin
        if (s) begin
          state_d = WAIT_HI;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      WAIT_HI: begin
        // Any reversion of s restarts qualification from zero.
        if (!s) begin
          state_d = STABLE_LO;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_MAX) begin
          state_d = STABLE_HI;
          db_d    = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      STABLE_HI: begin
        if (!s) begin
          state_d = WAIT_LO;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      WAIT_LO: begin
        if (s) begin
          state_d = STABLE_HI;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_MAX) begin
          state_d = STABLE_LO;
          db_d    = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RESET_STATE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
      state_q <= RESET_STATE;
      cnt_q   <= CNT_ZERO;
      db_q    <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign bus.db_out     = db_q;
  assign bus.rise_pulse = rise_q;
  assign bus.fall_pulse = fall_q;
  assign bus.dbg_state  = state_q;

`ifdef DEBOUNCER_TOGGLE_EN
  logic toggle_q, toggle_d;

  // Flips on the edge after the registered rise pulse.
  always_comb begin
    toggle_d = toggle_q ^ rise_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      toggle_q <= 1'b0;
    end else begin
      toggle_q <= toggle_d;
    end
  end

  assign bus.toggle_out = toggle_q;
`else
  assign bus.toggle_out = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with STABLE_CYCLES=4, SYNC_STAGES=2, RESET_LEVEL=0.
// Inputs change 1 ns after a rising edge; edge numbering starts at the first edge that samples them.
module tb_button_debouncer;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  button_debouncer_if bus();

  button_debouncer #(
    .STABLE_CYCLES(4),
    .SYNC_STAGES  (2),
    .RESET_LEVEL  (1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.btn_in = 1'b0;
    step();
    step();
    rst = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      step();
      total++;
      if (bus.db_out !== 1'b0) begin
        bad++;
        $display("FAIL reset_db edge=%0d got=%b exp=0", e, bus.db_out);
      end
      total++;
      if (bus.rise_pulse !== 1'b0 || bus.fall_pulse !== 1'b0) begin
        bad++;
        $display("FAIL reset_pulses edge=%0d got=%b%b exp=00", e, bus.rise_pulse, bus.fall_pulse);
      end
      total++;
      if (bus.toggle_out !== 1'b0) begin
        bad++;
        $display("FAIL reset_toggle edge=%0d got=%b exp=0", e, bus.toggle_out);
      end
    end
  endtask

  task automatic test_rise();
    logic exp_db;
    logic exp_rise;
    bus.btn_in = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      exp_db   = (e >= 6);
      exp_rise = (e == 6);
      total++;
      if (bus.db_out !== exp_db) begin
        bad++;
        $display("FAIL rise_db edge=%0d got=%b exp=%b", e, bus.db_out, exp_db);
      end
      total++;
      if (bus.rise_pulse !== exp_rise) begin
        bad++;
        $display("FAIL rise_pulse edge=%0d got=%b exp=%b", e, bus.rise_pulse, exp_rise);
      end
      total++;
      if (bus.fall_pulse !== 1'b0) begin
        bad++;
        $display("FAIL rise_nofall edge=%0d got=%b exp=0", e, bus.fall_pulse);
      end
    end
  endtask

  task automatic test_fall();
    logic exp_db;
    logic exp_fall;
    bus.btn_in = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step();
      exp_db   = (e < 6);
      exp_fall = (e == 6);
      total++;
      if (bus.db_out !== exp_db) begin
        bad++;
        $display("FAIL fall_db edge=%0d got=%b exp=%b", e, bus.db_out, exp_db);
      end
      total++;
      if (bus.fall_pulse !== exp_fall) begin
        bad++;
        $display("FAIL fall_pulse edge=%0d got=%b exp=%b", e, bus.fall_pulse, exp_fall);
      end
      total++;
      if (bus.rise_pulse !== 1'b0) begin
        bad++;
        $display("FAIL fall_norise edge=%0d got=%b exp=0", e, bus.rise_pulse);
      end
    end
  endtask

  // Pin pattern 1,1,1,0,1,1,1,0 then 1 held: only the final hold (from edge 9) qualifies, at edge 14.
  task automatic test_bounce();
    logic [17:0] pattern;
    logic        exp_db;
    logic        exp_rise;
    int          rises;
    pattern = 18'b11_1111_1111_0111_0111;
    rises = 0;
    for (int e = 1; e <= 18; e++) begin
      bus.btn_in = pattern[e-1];
      step();
      exp_db   = (e >= 14);
      exp_rise = (e == 14);
      if (bus.rise_pulse === 1'b1) rises++;
      total++;
      if (bus.db_out !== exp_db) begin
        bad++;
        $display("FAIL bounce_db edge=%0d got=%b exp=%b", e, bus.db_out, exp_db);
      end
      total++;
      if (bus.rise_pulse !== exp_rise || bus.fall_pulse !== 1'b0) begin
        bad++;
        $display("FAIL bounce_pulses edge=%0d got=%b%b exp=%b0", e, bus.rise_pulse, bus.fall_pulse, exp_rise);
      end
    end
    total++;
    if (rises != 1) begin
      bad++;
      $display("FAIL bounce_rise_count got=%0d exp=1", rises);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic exp_db;
    logic exp_rise;
    bus.btn_in = 1'b1;
    for (int e = 1; e <= 4; e++) step();
    total++;
    if (bus.dbg_state !== 2'd1) begin
      bad++;
      $display("FAIL midwait_state got=%0d exp=1", bus.dbg_state);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (bus.db_out !== 1'b0 || bus.dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL midwait_async db=%b state=%0d exp db=0 state=0", bus.db_out, bus.dbg_state);
    end
    step();
    step();
    rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step();
      exp_db   = (e >= 6);
      exp_rise = (e == 6);
      total++;
      if (bus.db_out !== exp_db) begin
        bad++;
        $display("FAIL midwait_requal_db edge=%0d got=%b exp=%b", e, bus.db_out, exp_db);
      end
      total++;
      if (bus.rise_pulse !== exp_rise) begin
        bad++;
        $display("FAIL midwait_requal_rise edge=%0d got=%b exp=%b", e, bus.rise_pulse, exp_rise);
      end
    end
    // db_out is high here; reset between edges must clear it without a clock.
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (bus.db_out !== 1'b0 || bus.dbg_state !== 2'd0) begin
      bad++;
      $display("FAIL async_clear_high db=%b state=%0d exp db=0 state=0", bus.db_out, bus.dbg_state);
    end
    bus.btn_in = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_toggle();
    logic t_now;
    logic t_exp;
    logic enabled;
`ifdef DEBOUNCER_TOGGLE_EN
    enabled = 1'b1;
`else
    enabled = 1'b0;
`endif
    t_now = 1'b0;
    for (int p = 0; p < 2; p++) begin
      bus.btn_in = 1'b1;
      for (int e = 1; e <= 8; e++) begin
        step();
        t_exp = (e >= 7) ? (t_now ^ enabled) : t_now;
        total++;
        if (bus.toggle_out !== t_exp) begin
          bad++;
          $display("FAIL toggle_press%0d edge=%0d got=%b exp=%b", p, e, bus.toggle_out, t_exp);
        end
      end
      t_now = t_now ^ enabled;
      bus.btn_in = 1'b0;
      for (int e = 1; e <= 8; e++) begin
        step();
        total++;
        if (bus.toggle_out !== t_now) begin
          bad++;
          $display("FAIL toggle_release%0d edge=%0d got=%b exp=%b", p, e, bus.toggle_out, t_now);
        end
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.btn_in = 1'b0;
    test_reset();
    test_rise();
    test_fall();
    test_bounce();
    test_fall();
    test_reset_mid_wait();
    test_toggle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
